// File: rtl/bram_ctrl_pkg.sv
// Shared state encoding and default geometry for the RX BRAM bank capture controller.
// Pure declarations; no timing or flow-control behaviour of its own.
package bram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_FILL     = 2'b01,
        ST_WAIT_LOW = 2'b10
    } state_e;

    localparam int DEF_NUM_BANKS      = 2;
    localparam int DEF_BANK_DEPTH     = 2048;
    localparam int DEF_BYTES_PER_WORD = 4;
    localparam int DEF_SIZE_W         = 32;

endpackage

// File: rtl/bram_bank_ctrl.sv
// N-bank capture sequencer: fills banks in order during a sinc window, reports word count; all outputs registered, 1-cycle latency.
// No backpressure: a window start is refused (sticky overrun) while any reader bank is still draining.
module bram_bank_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter int NUM_BANKS      = DEF_NUM_BANKS,
    parameter int BANK_DEPTH     = DEF_BANK_DEPTH,
    parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
    parameter int SIZE_W         = DEF_SIZE_W,
    parameter int IDX_W          = $clog2(NUM_BANKS)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic                 sinc,
    input  logic                 sinc_edge,
    input  logic [31:0]          addr,
    input  logic [NUM_BANKS-1:0] rdy_w,
    output logic                 rst_count,
    output logic [NUM_BANKS-1:0] bank_en,
    output logic [IDX_W-1:0]     bank_idx,
    output logic [NUM_BANKS-1:0] rdy,
    output logic                 done,
    output logic                 partial,
    output logic                 overrun,
    output logic [SIZE_W-1:0]    size_data
);

    localparam int                DEPTH_SH  = $clog2(BANK_DEPTH);
    localparam int                BPW_SH    = $clog2(BYTES_PER_WORD);
    localparam logic [SIZE_W-1:0] FULL_SIZE = SIZE_W'(NUM_BANKS * BANK_DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_BANKS - 1);

    state_e                state_q, state_d;
    logic                  rst_count_q, rst_count_d;
    logic [NUM_BANKS-1:0]  bank_en_q, bank_en_d;
    logic [IDX_W-1:0]      bank_idx_q, bank_idx_d;
    logic [NUM_BANKS-1:0]  rdy_q, rdy_d;
    logic                  done_q, done_d;
    logic                  partial_q, partial_d;
    logic                  overrun_q, overrun_d;
    logic [SIZE_W-1:0]     size_q, size_d;
    logic [SIZE_W-1:0]     early_size;

    // Words already written in full banks plus the word at addr itself.
    assign early_size = (SIZE_W'(bank_idx_q) << DEPTH_SH)
                      + SIZE_W'(addr >> BPW_SH)
                      + SIZE_W'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            rst_count_q <= 1'b1;
            bank_en_q   <= '0;
            bank_idx_q  <= '0;
            rdy_q       <= '0;
            done_q      <= 1'b0;
            partial_q   <= 1'b0;
            overrun_q   <= 1'b0;
            size_q      <= '0;
        end else begin
            state_q     <= state_d;
            rst_count_q <= rst_count_d;
            bank_en_q   <= bank_en_d;
            bank_idx_q  <= bank_idx_d;
            rdy_q       <= rdy_d;
            done_q      <= done_d;
            partial_q   <= partial_d;
            overrun_q   <= overrun_d;
            size_q      <= size_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rst_count_d = rst_count_q;
        bank_en_d   = bank_en_q;
        bank_idx_d  = bank_idx_q;
        rdy_d       = rdy_q;
        done_d      = 1'b0;
        partial_d   = partial_q;
        overrun_d   = overrun_q;
        size_d      = size_q;

        case (state_q)
            ST_IDLE: begin
                rst_count_d = 1'b1;
                bank_en_d   = '0;
                if (sinc_edge) begin
                    if (rdy_w == '0) begin
                        state_d     = ST_FILL;
                        rst_count_d = 1'b0;
                        bank_en_d   = NUM_BANKS'(1);
                        bank_idx_d  = '0;
                        rdy_d       = '0;
                        partial_d   = 1'b0;
                        overrun_d   = 1'b0;
                        size_d      = '0;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end

            ST_FILL: begin
                // Counter reset released here, so a bank-switch pulse lasts one cycle.
                rst_count_d = 1'b0;
                if (sinc_edge) begin
                    overrun_d = 1'b1;
                end
                if (!sinc) begin
                    state_d     = ST_IDLE;
                    size_d      = early_size;
                    for (int i = 0; i < NUM_BANKS; i++) begin
                        if (i <= int'(bank_idx_q)) begin
                            rdy_d[i] = 1'b1;
                        end
                    end
                    partial_d   = 1'b1;
                    done_d      = 1'b1;
                    bank_en_d   = '0;
                    rst_count_d = 1'b1;
                end else if (en && (bank_idx_q == LAST_IDX)) begin
                    state_d     = ST_WAIT_LOW;
                    size_d      = FULL_SIZE;
                    rdy_d       = '1;
                    partial_d   = 1'b0;
                    done_d      = 1'b1;
                    bank_en_d   = '0;
                    rst_count_d = 1'b1;
                end else if (en) begin
                    rdy_d[bank_idx_q] = 1'b1;
                    bank_idx_d        = bank_idx_q + IDX_W'(1);
                    bank_en_d         = bank_en_q << 1;
                    rst_count_d       = 1'b1;
                end
            end

            ST_WAIT_LOW: begin
                rst_count_d = 1'b1;
                bank_en_d   = '0;
                if (sinc_edge) begin
                    overrun_d = 1'b1;
                end
                if (!sinc) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                rst_count_d = 1'b1;
                bank_en_d   = '0;
                bank_idx_d  = '0;
                rdy_d       = '0;
                partial_d   = 1'b0;
                overrun_d   = 1'b0;
                size_d      = '0;
            end
        endcase
    end

    assign rst_count = rst_count_q;
    assign bank_en   = bank_en_q;
    assign bank_idx  = bank_idx_q;
    assign rdy       = rdy_q;
    assign done      = done_q;
    assign partial   = partial_q;
    assign overrun   = overrun_q;
    assign size_data = size_q;

endmodule

// File: tb/tb_bram_bank_ctrl.sv
// Directed bench for bram_bank_ctrl: a 2-bank and a 4-bank instance share stimulus.
module tb_bram_bank_ctrl;

    logic        clk;
    logic        rstn;
    logic        en;
    logic        sinc;
    logic        sinc_edge;
    logic [31:0] addr;
    logic [1:0]  rdy_w2;
    logic [3:0]  rdy_w4;

    logic        rc2, done2, part2, ovr2;
    logic [1:0]  ben2, rdy2;
    logic [0:0]  idx2;
    logic [31:0] size2;

    logic        rc4, done4, part4, ovr4;
    logic [3:0]  ben4, rdy4;
    logic [1:0]  idx4;
    logic [31:0] size4;

    int n_pass  = 0;
    int n_total = 0;

    bram_bank_ctrl #(.NUM_BANKS(2), .BANK_DEPTH(2048), .BYTES_PER_WORD(4), .SIZE_W(32), .IDX_W(1)) u2 (
        .clk(clk), .rstn(rstn), .en(en), .sinc(sinc), .sinc_edge(sinc_edge), .addr(addr),
        .rdy_w(rdy_w2), .rst_count(rc2), .bank_en(ben2), .bank_idx(idx2), .rdy(rdy2),
        .done(done2), .partial(part2), .overrun(ovr2), .size_data(size2)
    );

    bram_bank_ctrl #(.NUM_BANKS(4), .BANK_DEPTH(2048), .BYTES_PER_WORD(4), .SIZE_W(32), .IDX_W(2)) u4 (
        .clk(clk), .rstn(rstn), .en(en), .sinc(sinc), .sinc_edge(sinc_edge), .addr(addr),
        .rdy_w(rdy_w4), .rst_count(rc4), .bank_en(ben4), .bank_idx(idx4), .rdy(rdy4),
        .done(done4), .partial(part4), .overrun(ovr4), .size_data(size4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic chk_reset2(input string tag);
        chk({tag, ".rst_count"}, 32'(rc2), 32'd1);
        chk({tag, ".bank_en"}, 32'(ben2), 32'd0);
        chk({tag, ".bank_idx"}, 32'(idx2), 32'd0);
        chk({tag, ".rdy"}, 32'(rdy2), 32'd0);
        chk({tag, ".done"}, 32'(done2), 32'd0);
        chk({tag, ".partial"}, 32'(part2), 32'd0);
        chk({tag, ".overrun"}, 32'(ovr2), 32'd0);
        chk({tag, ".size"}, size2, 32'd0);
    endtask

    task automatic start_window();
        sinc      = 1'b1;
        sinc_edge = 1'b1;
        tick();
        sinc_edge = 1'b0;
    endtask

    task automatic pulse_en();
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; sinc = 1'b0; sinc_edge = 1'b0;
        addr = 32'd0; rdy_w2 = 2'b00; rdy_w4 = 4'b0000;
        tick();
        tick();
        chk_reset2("reset");
        rstn = 1'b1;
        tick();

        // Full two-bank capture
        start_window();
        chk("full.start.bank_en", 32'(ben2), 32'h1);
        chk("full.start.rst_count", 32'(rc2), 32'd0);
        pulse_en();
        chk("full.sw.bank_en", 32'(ben2), 32'h2);
        chk("full.sw.bank_idx", 32'(idx2), 32'd1);
        chk("full.sw.rdy", 32'(rdy2), 32'h1);
        chk("full.sw.rst_count_hi", 32'(rc2), 32'd1);
        tick();
        chk("full.sw.rst_count_lo", 32'(rc2), 32'd0);
        chk("full.sw.done_lo", 32'(done2), 32'd0);
        pulse_en();
        chk("full.end.bank_en", 32'(ben2), 32'h0);
        chk("full.end.size", size2, 32'd4096);
        chk("full.end.rdy", 32'(rdy2), 32'h3);
        chk("full.end.done", 32'(done2), 32'd1);
        chk("full.end.partial", 32'(part2), 32'd0);
        chk("full.end.rst_count", 32'(rc2), 32'd1);
        tick();
        chk("full.done_one_cycle", 32'(done2), 32'd0);
        sinc_edge = 1'b1;
        tick();
        sinc_edge = 1'b0;
        chk("waitlow.no_restart", 32'(ben2), 32'h0);
        chk("waitlow.overrun", 32'(ovr2), 32'd1);
        sinc = 1'b0;
        tick();

        // Early end in bank 1 at addr 0x1FC
        start_window();
        chk("early1.start.overrun_clr", 32'(ovr2), 32'd0);
        chk("early1.start.rdy_clr", 32'(rdy2), 32'h0);
        chk("early1.start.size_clr", size2, 32'd0);
        pulse_en();
        tick();
        addr = 32'h1FC;
        sinc = 1'b0;
        tick();
        chk("early1.size", size2, 32'd2176);
        chk("early1.rdy", 32'(rdy2), 32'h3);
        chk("early1.partial", 32'(part2), 32'd1);
        chk("early1.done", 32'(done2), 32'd1);
        chk("early1.bank_en", 32'(ben2), 32'h0);
        tick();
        chk("early1.done_lo", 32'(done2), 32'd0);

        // Early end in bank 0 at addr 0
        start_window();
        addr = 32'h0;
        sinc = 1'b0;
        tick();
        chk("early0.size", size2, 32'd1);
        chk("early0.rdy", 32'(rdy2), 32'h1);
        chk("early0.partial", 32'(part2), 32'd1);

        // Refused start while reader drains bank 1
        rdy_w2 = 2'b10;
        start_window();
        chk("refuse.bank_en", 32'(ben2), 32'h0);
        chk("refuse.overrun", 32'(ovr2), 32'd1);
        chk("refuse.rdy_held", 32'(rdy2), 32'h1);
        chk("refuse.rst_count", 32'(rc2), 32'd1);
        sinc = 1'b0;
        rdy_w2 = 2'b00;
        tick();
        start_window();
        chk("accept.bank_en", 32'(ben2), 32'h1);
        chk("accept.overrun_clr", 32'(ovr2), 32'd0);
        chk("accept.rdy_clr", 32'(rdy2), 32'h0);

        // Asynchronous reset in bank 1
        pulse_en();
        chk("rstmid.in_bank1", 32'(idx2), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk_reset2("rstmid");
        tick();
        chk("rstmid.no_done", 32'(done2), 32'd0);
        sinc = 1'b0;
        rstn = 1'b1;
        tick();
        start_window();
        chk("rstmid.restart.bank_en", 32'(ben2), 32'h1);
        chk("rstmid.restart.bank_idx", 32'(idx2), 32'd0);

        // Simultaneous sinc fall and en at last word of bank 0
        addr = 32'h1FFC;
        sinc = 1'b0;
        en   = 1'b1;
        tick();
        en = 1'b0;
        chk("simul.size", size2, 32'd2048);
        chk("simul.partial", 32'(part2), 32'd1);
        chk("simul.rdy", 32'(rdy2), 32'h1);
        chk("simul.bank_idx", 32'(idx2), 32'd0);

        // Four-bank instance from a clean reset
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        addr = 32'h0;
        tick();
        start_window();
        chk("nb4.start.bank_en", 32'(ben4), 32'h1);
        pulse_en();
        chk("nb4.sw1.bank_idx", 32'(idx4), 32'd1);
        pulse_en();
        chk("nb4.sw2.bank_en", 32'(ben4), 32'h4);
        pulse_en();
        chk("nb4.sw3.bank_idx", 32'(idx4), 32'd3);
        chk("nb4.sw3.bank_en", 32'(ben4), 32'h8);
        chk("nb4.sw3.rdy", 32'(rdy4), 32'h7);
        addr = 32'h10;
        sinc = 1'b0;
        tick();
        chk("nb4.size", size4, 32'd6149);
        chk("nb4.rdy", 32'(rdy4), 32'hF);
        chk("nb4.partial", 32'(part4), 32'd1);
        chk("nb4.done", 32'(done4), 32'd1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
